// File: rtl/rf_host_pkg.sv
// Shared types and constants for the host-to-register-file command bridge.
// Covers the FSM state encoding, protocol bytes and the TPU control register map.
package rf_host_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    WAIT_RDY = 3'd3,
    WRITE    = 3'd4,
    READ     = 3'd5,
    SEND     = 3'd6
  } state_t;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RESP_ACK = 8'h4B;
  localparam logic [7:0] RESP_NAK = 8'h45;

  // TPU control block register addresses
  localparam logic [7:0] RF_CTRL   = 8'h20;
  localparam logic [7:0] RF_STATUS = 8'h21;
  localparam logic [7:0] RF_SRC    = 8'h22;
  localparam logic [7:0] RF_DST    = 8'h23;
  localparam logic [7:0] RF_LEN    = 8'h24;

  function automatic logic is_opcode(input logic [7:0] b, input logic [7:0] op_wr,
                                     input logic [7:0] op_rd);
    return (b == op_wr) || (b == op_rd);
  endfunction

endpackage

// File: rtl/rf_host_timeout.sv
// Inter-byte timeout counter: clears on demand, counts while enabled and
// flags expiry on its last count.
module rf_host_timeout
  import rf_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/rf_host_bridge.sv
// Byte-stream command decoder that drives single register-file accesses and
// returns one response byte per command.
module rf_host_bridge
  import rf_host_pkg::*;
#(
  parameter int         REG_DEPTH      = 64,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] OP_WR          = CMD_WR,
  parameter logic [7:0] OP_RD          = CMD_RD,
  parameter logic [7:0] RSP_ACK        = RESP_ACK,
  parameter logic [7:0] RSP_NAK        = RESP_NAK
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       ready_rf,
  input  logic [7:0] data_out,
  output logic       we_rf,
  output logic [7:0] addr_rf,
  output logic [7:0] data_rf,
  output logic       busy,
  output logic       rx_overrun
);

  localparam logic [8:0] DEPTH = 9'(REG_DEPTH);

  state_t state;
  logic   is_wr;
  logic   expire;
  logic   tmo_clr;
  logic   tmo_en;
  logic   addr_bad;
  logic   drop_state;

  assign tmo_en     = (state == GET_ADDR) || (state == GET_DATA);
  assign tmo_clr    = (state == IDLE) || rx_valid;
  assign addr_bad   = {1'b0, rx_data} >= DEPTH;
  assign drop_state = (state == WAIT_RDY) || (state == WRITE) ||
                      (state == READ) || (state == SEND);

  rf_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (SYS_CLK),
    .rst   (RST),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .expire(expire)
  );

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      is_wr      <= 1'b0;
      we_rf      <= 1'b0;
      addr_rf    <= '0;
      data_rf    <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      we_rf      <= 1'b0;
      rx_overrun <= rx_valid && drop_state;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            busy <= 1'b1;
            if (is_opcode(rx_data, OP_WR, OP_RD)) begin
              is_wr <= (rx_data == OP_WR);
              state <= GET_ADDR;
            end else begin
              tx_data  <= RSP_NAK;
              tx_valid <= 1'b1;
              state    <= SEND;
            end
          end
        end
        GET_ADDR: begin
          // An arriving byte wins over a simultaneous expiry
          if (rx_valid) begin
            addr_rf <= rx_data;
            if (addr_bad) begin
              tx_data  <= RSP_NAK;
              tx_valid <= 1'b1;
              state    <= SEND;
            end else begin
              state <= is_wr ? GET_DATA : WAIT_RDY;
            end
          end else if (expire) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            data_rf <= rx_data;
            state   <= WAIT_RDY;
          end else if (expire) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT_RDY: begin
          if (ready_rf) begin
            if (is_wr) begin
              we_rf <= 1'b1;
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          tx_data  <= RSP_ACK;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        READ: begin
          // addr_rf has been held since WAIT_RDY, so data_out is settled here
          tx_data  <= data_out;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_host_bridge.sv
// Directed bench for rf_host_bridge: a small register-file model, a scoreboard
// of expected response bytes and writes, and a handshake monitor.
module tb_rf_host_bridge;

  localparam int T = 40;

  logic       SYS_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;
  logic       ready_rf = 1'b1;
  logic [7:0] data_out;
  logic       we_rf;
  logic [7:0] addr_rf;
  logic [7:0] data_rf;
  logic       busy;
  logic       rx_overrun;

  int tests = 0;
  int fails = 0;
  int n_we = 0;
  int n_tx = 0;
  int n_ovr = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_wa[$];
  logic [7:0] exp_wd[$];
  logic [7:0] mem[64];

  rf_host_bridge #(
    .REG_DEPTH(64),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .ready_rf  (ready_rf),
    .data_out  (data_out),
    .we_rf     (we_rf),
    .addr_rf   (addr_rf),
    .data_rf   (data_rf),
    .busy      (busy),
    .rx_overrun(rx_overrun)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  assign data_out = mem[addr_rf[5:0]];

  always @(posedge SYS_CLK) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[6'h20] <= 8'hA7;
      mem[6'h22] <= 8'h3C;
    end else if (we_rf) begin
      mem[addr_rf[5:0]] <= data_rf;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops on each response handshake and each write strobe
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge SYS_CLK) begin
    if (rx_overrun === 1'b1) n_ovr++;
    if (tx_valid === 1'b1 && prev_hold) check("tx_hold", tx_data, prev_data);
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      n_tx++;
      if (exp_tx.size() == 0) check("tx_unexpected", tx_data, 32'hFFFF_FFFF);
      else check("tx_data", tx_data, exp_tx.pop_front());
    end
    if (we_rf === 1'b1) begin
      n_we++;
      if (exp_wa.size() == 0) check("we_unexpected", addr_rf, 32'hFFFF_FFFF);
      else begin
        check("we_addr", addr_rf, exp_wa.pop_front());
        check("we_data", data_rf, exp_wd.pop_front());
      end
    end
    prev_hold = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
    prev_data = tx_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge SYS_CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge SYS_CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge SYS_CLK);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge SYS_CLK);
      n++;
    end
    check(tag, busy, 0);
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_txv(input string tag);
    int n = 0;
    @(negedge SYS_CLK);
    while (tx_valid !== 1'b1 && n < 200) begin
      @(negedge SYS_CLK);
      n++;
    end
    check(tag, tx_valid, 1);
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, we_rf, 0);
    check({tag, "_addr"}, addr_rf, 0);
    check({tag, "_data"}, data_rf, 0);
    check({tag, "_txv"}, tx_valid, 0);
    check({tag, "_txd"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovr"}, rx_overrun, 0);
  endtask

  initial begin
    int we0, tx0, ov0;
    tick(2);
    check_zero("reset");
    @(negedge SYS_CLK);
    RST = 1'b0;
    tick(2);

    // 1: write
    we0 = n_we; tx0 = n_tx;
    exp_wa.push_back(8'h21); exp_wd.push_back(8'h5A); exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h21); send_byte(8'h5A);
    wait_idle("t1_idle");
    check("t1_we_count", n_we - we0, 1);
    check("t1_tx_count", n_tx - tx0, 1);

    // 2: read held off by ready_rf, then readback of the write
    we0 = n_we; tx0 = n_tx;
    ready_rf = 1'b0;
    exp_tx.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'h22);
    tick(5);
    check("t2_no_tx_before_rdy", n_tx - tx0, 0);
    check("t2_busy_wait", busy, 1);
    ready_rf = 1'b1;
    wait_idle("t2_idle");
    exp_tx.push_back(8'h5A);
    send_byte(8'h52); send_byte(8'h21);
    wait_idle("t2_rb_idle");
    check("t2_no_we", n_we - we0, 0);
    check("t2_tx_count", n_tx - tx0, 2);

    // 3: bad opcode, bad address, trailing byte as opcode
    we0 = n_we; tx0 = n_tx;
    exp_tx.push_back(8'h45);
    send_byte(8'h41);
    wait_idle("t3_op_idle");
    exp_tx.push_back(8'h45);
    send_byte(8'h57); send_byte(8'h40);
    wait_idle("t3_addr_idle");
    exp_tx.push_back(8'h45);
    send_byte(8'h5A);
    wait_idle("t3_third_idle");
    check("t3_no_we", n_we - we0, 0);
    check("t3_tx_count", n_tx - tx0, 3);

    // 4: timeout, recovery read, and a byte on the exact expiry cycle
    we0 = n_we; tx0 = n_tx;
    send_byte(8'h57);
    tick(T - 5);
    check("t4_busy_before", busy, 1);
    tick(10);
    check("t4_busy_after", busy, 0);
    check("t4_no_tx", n_tx - tx0, 0);
    exp_tx.push_back(8'hA7);
    send_byte(8'h52); send_byte(8'h20);
    wait_idle("t4_read_idle");
    exp_wa.push_back(8'h21); exp_wd.push_back(8'h66); exp_tx.push_back(8'h4B);
    send_byte(8'h57);
    tick(T - 1);
    send_byte(8'h21); send_byte(8'h66);
    wait_idle("t4_edge_idle");
    check("t4_we_count", n_we - we0, 1);
    check("t4_tx_count", n_tx - tx0, 2);

    // 5: tx backpressure with a dropped byte, then ready_rf stall
    we0 = n_we; tx0 = n_tx; ov0 = n_ovr;
    tx_ready = 1'b0;
    exp_wa.push_back(8'h23); exp_wd.push_back(8'h77); exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h23); send_byte(8'h77);
    wait_txv("t5_txv");
    tick(8);
    send_byte(8'h99);
    tick(11);
    check("t5_tx_held", tx_valid, 1);
    check("t5_no_tx", n_tx - tx0, 0);
    check("t5_ovr_count", n_ovr - ov0, 1);
    tx_ready = 1'b1;
    wait_idle("t5_tx_idle");
    check("t5_tx_count", n_tx - tx0, 1);
    we0 = n_we;
    ready_rf = 1'b0;
    exp_wa.push_back(8'h24); exp_wd.push_back(8'h88); exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h24); send_byte(8'h88);
    tick(10);
    check("t5_we_delayed", n_we - we0, 0);
    ready_rf = 1'b1;
    wait_idle("t5_rdy_idle");
    check("t5_we_count", n_we - we0, 1);

    // 6: reset in GET_DATA and in SEND
    we0 = n_we; tx0 = n_tx;
    send_byte(8'h57); send_byte(8'h25);
    RST = 1'b1;
    #1;
    check_zero("t6_getdata");
    @(negedge SYS_CLK);
    RST = 1'b0;
    tick(5);
    tx_ready = 1'b0;
    send_byte(8'h41);
    tick(1);
    check("t6_send_txv", tx_valid, 1);
    RST = 1'b1;
    #1;
    check_zero("t6_send");
    @(negedge SYS_CLK);
    RST = 1'b0;
    tx_ready = 1'b1;
    tick(5);
    check("t6_no_we", n_we - we0, 0);
    check("t6_no_tx", n_tx - tx0, 0);

    check("end_tx_queue", exp_tx.size(), 0);
    check("end_we_queue", exp_wa.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
